// File: rtl/mdu_iter_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states, constants.
package mdu_iter_pkg;

  localparam int unsigned OP_W   = 3;
  localparam int unsigned WORD_W = 32;

  localparam logic [OP_W-1:0] OP_MULT  = 3'b000;
  localparam logic [OP_W-1:0] OP_MULTU = 3'b001;
  localparam logic [OP_W-1:0] OP_DIV   = 3'b010;
  localparam logic [OP_W-1:0] OP_DIVU  = 3'b011;
  localparam logic [OP_W-1:0] OP_MADD  = 3'b100;
  localparam logic [OP_W-1:0] OP_MADDU = 3'b101;
  localparam logic [OP_W-1:0] OP_MSUB  = 3'b110;
  localparam logic [OP_W-1:0] OP_MSUBU = 3'b111;

  localparam logic [WORD_W-1:0] ZERO_WORD = '0;
  localparam logic              RST_LEVEL = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_CALC = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  function automatic logic op_is_base(input logic [OP_W-1:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_div(input logic [OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [OP_W-1:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic op_is_macc(input logic [OP_W-1:0] op);
    return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  function automatic logic op_is_msub(input logic [OP_W-1:0] op);
    return (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring division step: shift {rem,quo} left, subtract divisor if it fits.
module mdu_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next_c,
  output logic [WIDTH-1:0] quo_next_c
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial;
  logic             fits;

  // rem < divisor on entry, so a successful trial always fits in WIDTH bits
  assign shifted    = {rem, quo[WIDTH-1]};
  assign fits       = (shifted >= {1'b0, divisor});
  assign trial      = shifted[WIDTH-1:0] - divisor;
  assign rem_next_c = fits ? trial : shifted[WIDTH-1:0];
  assign quo_next_c = {quo[WIDTH-2:0], fits};

endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit, one bit per cycle, feeding the HI/LO stage.
// MDU_MACC_EN adds MADD/MADDU/MSUB/MSUBU (accumulate into latched HI/LO).
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] opdata1_i,
  input  logic [WIDTH-1:0] opdata2_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned DW = 2 * WIDTH;

  state_t           state, state_n;
  logic [2:0]       op_q, op_n;
  logic [WIDTH-1:0] a_q, a_n, b_q, b_n, opnd_q, opnd_n;
  logic [DW-1:0]    acc_q, acc_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             sgn_q_q, sgn_q_n, sgn_r_q, sgn_r_n, dz_q, dz_n;
  logic             busy_n, done_n;
  logic [WIDTH-1:0] hi_n, lo_n;

  logic             is_div, is_signed, op_ok;
  logic [WIDTH-1:0] mag_a, mag_b, div_rem, div_quo, quo_fix, rem_fix;
  logic [WIDTH:0]   mul_sum;
  logic [DW-1:0]    prod_fix, mul_res, fix_res;

  assign is_div    = op_is_div(op_q);
  assign is_signed = op_is_signed(op_q);
  assign mag_a     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
  assign mag_b     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

  // Shift-add: acc = {partial product, remaining multiplier bits}
  assign mul_sum = {1'b0, acc_q[DW-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : (WIDTH+1)'(0));

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem        (acc_q[DW-1:WIDTH]),
    .quo        (acc_q[WIDTH-1:0]),
    .divisor    (opnd_q),
    .rem_next_c (div_rem),
    .quo_next_c (div_quo)
  );

  assign prod_fix = (is_signed && sgn_q_q) ? -acc_q : acc_q;
  assign quo_fix  = (is_signed && sgn_q_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = (is_signed && sgn_r_q) ? -acc_q[DW-1:WIDTH] : acc_q[DW-1:WIDTH];

`ifdef MDU_MACC_EN
  logic [DW-1:0] base_q, base_n;
  assign op_ok   = 1'b1;
  assign mul_res = op_is_macc(op_q) ? (op_is_msub(op_q) ? base_q - prod_fix : base_q + prod_fix)
                                    : prod_fix;
`else
  logic unused_macc;
  assign unused_macc = ^{hi_i, lo_i};
  assign op_ok       = op_is_base(op_i);
  assign mul_res     = prod_fix;
`endif

  // Divide by zero yields a fixed pattern instead of trapping
  assign fix_res = dz_q   ? {a_q, {WIDTH{1'b1}}} :
                   is_div ? {rem_fix, quo_fix}   : mul_res;

  // Next-state and datapath next values
  always_comb begin
    state_n = state;
    op_n    = op_q;
    a_n     = a_q;
    b_n     = b_q;
    opnd_n  = opnd_q;
    acc_n   = acc_q;
    cnt_n   = cnt_q;
    sgn_q_n = sgn_q_q;
    sgn_r_n = sgn_r_q;
    dz_n    = dz_q;
    hi_n    = hi_o;
    lo_n    = lo_o;
`ifdef MDU_MACC_EN
    base_n  = base_q;
`endif
    case (state)
      ST_IDLE: begin
        if (start_i && !flush_i && op_ok) begin
          op_n    = op_i;
          a_n     = opdata1_i;
          b_n     = opdata2_i;
`ifdef MDU_MACC_EN
          base_n  = {hi_i, lo_i};
`endif
          state_n = ST_PREP;
        end
      end
      ST_PREP: begin
        sgn_q_n = a_q[WIDTH-1] ^ b_q[WIDTH-1];
        sgn_r_n = a_q[WIDTH-1];
        dz_n    = is_div && (b_q == '0);
        cnt_n   = '0;
        opnd_n  = is_div ? mag_b : mag_a;
        acc_n   = {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
        state_n = ST_CALC;
      end
      ST_CALC: begin
        acc_n = is_div ? {div_rem, div_quo} : {mul_sum, acc_q[WIDTH-1:1]};
        cnt_n = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_n = ST_FIX;
      end
      ST_FIX: begin
        hi_n    = fix_res[DW-1:WIDTH];
        lo_n    = fix_res[WIDTH-1:0];
        state_n = ST_DONE;
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    if (flush_i) begin
      state_n = ST_IDLE;
      hi_n    = hi_o;
      lo_n    = lo_o;
    end
    busy_n = (state_n != ST_IDLE);
    done_n = (state_n == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_LEVEL) begin
      state   <= ST_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sgn_q_q <= 1'b0;
      sgn_r_q <= 1'b0;
      dz_q    <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      hi_o    <= WIDTH'(ZERO_WORD);
      lo_o    <= WIDTH'(ZERO_WORD);
`ifdef MDU_MACC_EN
      base_q  <= '0;
`endif
    end else begin
      state   <= state_n;
      op_q    <= op_n;
      a_q     <= a_n;
      b_q     <= b_n;
      opnd_q  <= opnd_n;
      acc_q   <= acc_n;
      cnt_q   <= cnt_n;
      sgn_q_q <= sgn_q_n;
      sgn_r_q <= sgn_r_n;
      dz_q    <= dz_n;
      busy_o  <= busy_n;
      done_o  <= done_n;
      hi_o    <= hi_n;
      lo_o    <= lo_n;
`ifdef MDU_MACC_EN
      base_q  <= base_n;
`endif
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed + randomized bench for mdu_iter against an arithmetic reference model.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, flush;
  logic [2:0]  op;
  logic [31:0] opa, opb, hi_in, lo_in;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mdu_iter #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start),
    .flush_i   (flush),
    .op_i      (op),
    .opdata1_i (opa),
    .opdata2_i (opb),
    .hi_i      (hi_in),
    .lo_i      (lo_in),
    .busy_o    (busy),
    .done_o    (done),
    .hi_o      (hi),
    .lo_o      (lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; {hi,lo} = product or {remainder,quotient}
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] h, input logic [31:0] l);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = {32'h0, a};
    longint unsigned ub = {32'h0, b};
    longint          q, r;
    logic   [63:0]   acc = {h, l};
    case (o)
      3'd0: return 64'(sa * sb);
      3'd1: return ua * ub;
      3'd2: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      3'd4: return acc + 64'(sa * sb);
      3'd5: return acc + ua * ub;
      3'd6: return acc - 64'(sa * sb);
      default: return acc - ua * ub;
    endcase
  endfunction

  // Issue one op at a negedge (cycle 0); expect done_o in cycle 35 and busy_o over 1..35
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] h, input logic [31:0] l,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int lat;
    int busy_bad;
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b; hi_in = h; lo_in = l;
    @(negedge clk);
    start = 1'b0; opa = $urandom; opb = $urandom; hi_in = $urandom; lo_in = $urandom;
    lat = 1;
    busy_bad = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy !== 1'b1) busy_bad++;
      @(negedge clk);
      lat++;
    end
    if (busy !== 1'b1) busy_bad++;
    check({tag, ".latency"}, 64'(lat), 64'd35);
    check({tag, ".busy"}, 64'(busy_bad), 64'd0);
    check({tag, ".hi"}, {32'h0, hi}, {32'h0, ehi});
    check({tag, ".lo"}, {32'h0, lo}, {32'h0, elo});
    @(negedge clk);
    check({tag, ".idle"}, {62'h0, busy, done}, 64'd0);
  endtask

  initial begin
    logic [63:0] exp;
    logic [2:0]  ro;
    logic [31:0] ra, rb, rh, rl;
    int          done_seen, busy_bad;

    rst = 1'b0; start = 1'b0; flush = 1'b0; op = '0;
    opa = '0; opb = '0; hi_in = '0; lo_in = '0;
    repeat (2) @(negedge clk);
    check("reset.hilo", {hi, lo}, 64'd0);
    check("reset.ctl", {62'h0, busy, done}, 64'd0);
    rst = 1'b1;

    run_op("divu_100_7",   3'd3, 32'd100,      32'd7,        0, 0, 32'd2,        32'd14);
    run_op("div_m7_2",     3'd2, 32'hFFFFFFF9, 32'd2,        0, 0, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_min_m1",   3'd2, 32'h80000000, 32'hFFFFFFFF, 0, 0, 32'h0,        32'h80000000);
    run_op("mult_m1_2",    3'd0, 32'hFFFFFFFF, 32'd2,        0, 0, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("multu_m1_2",   3'd1, 32'hFFFFFFFF, 32'd2,        0, 0, 32'h1,        32'hFFFFFFFE);
    run_op("divu_5_0",     3'd3, 32'd5,        32'd0,        0, 0, 32'd5,        32'hFFFFFFFF);
    run_op("div_min_0",    3'd2, 32'h80000000, 32'd0,        0, 0, 32'h80000000, 32'hFFFFFFFF);

    // Flush mid-MULT with stray start pulses, then restart
    @(negedge clk);
    start = 1'b1; op = 3'd0; opa = 32'd3; opb = 32'd4;
    done_seen = 0;
    busy_bad = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = (c >= 5 && c <= 8);
      op    = 3'd3;
      opa   = $urandom;
      opb   = $urandom_range(1, 9);
      flush = (c == 10);
      if (done === 1'b1) done_seen++;
      if (busy !== 1'b1) busy_bad++;
    end
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    if (done === 1'b1) done_seen++;
    check("flush.busy_1_10", 64'(busy_bad), 64'd0);
    check("flush.busy_11", {63'h0, busy}, 64'd0);
    check("flush.no_done", 64'(done_seen), 64'd0);
    run_op("flush_restart", 3'd0, 32'd3, 32'd4, 0, 0, 32'd0, 32'd12);

    // Asynchronous reset mid-DIV, asserted between clock edges
    @(negedge clk);
    start = 1'b1; op = 3'd2; opa = 32'd1000; opb = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("areset.hilo", {hi, lo}, 64'd0);
    check("areset.ctl", {62'h0, busy, done}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    run_op("divu_9_3", 3'd3, 32'd9, 32'd3, 0, 0, 32'd0, 32'd3);

`ifdef MDU_MACC_EN
    run_op("madd_3_4", 3'd4, 32'd3, 32'd4, 32'd0, 32'd10, 32'd0,        32'd22);
    run_op("msub_3_4", 3'd6, 32'd3, 32'd4, 32'd0, 32'd10, 32'hFFFFFFFF, 32'hFFFFFFFE);
`else
    @(negedge clk);
    start = 1'b1; op = 3'd4; opa = 32'd3; opb = 32'd4;
    busy_bad = 0;
    done_seen = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy !== 1'b0) busy_bad++;
      if (done !== 1'b0) done_seen++;
    end
    check("op1xx.busy", 64'(busy_bad), 64'd0);
    check("op1xx.done", 64'(done_seen), 64'd0);
`endif

    for (int i = 0; i < 24; i++) begin
`ifdef MDU_MACC_EN
      ro = 3'($urandom_range(0, 7));
`else
      ro = 3'($urandom_range(0, 3));
`endif
      ra = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        2:       rb = 32'hFFFFFFFF;
        3:       begin rb = $urandom; ra = 32'h80000000; end
        default: rb = $urandom;
      endcase
      rh = $urandom;
      rl = $urandom;
      exp = model(ro, ra, rb, rh, rl);
      run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, rh, rl, exp[63:32], exp[31:0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative multiply/divide unit that sits directly upstream of the HI/LO register stage.
- Executes MULT/MULTU/DIV/DIVU at one bit per cycle (shift-add / restoring shift-subtract).
- Presents a 64-bit result as hi_o/lo_o with a one-cycle done_o write strobe that the HI/LO stage consumes.
- busy_o stalls the pipeline while an operation is in flight.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH (hi:lo).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start_i  in  1  request; sampled only in IDLE.
- flush_i  in  1  abort of the in-flight operation (exception/branch flush).
- op_i  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU; 1xx: see Optional Feature.
- opdata1_i  in  WIDTH  rs operand (multiplicand / dividend).
- opdata2_i  in  WIDTH  rt operand (multiplier / divisor).
- hi_i  in  WIDTH  current HI value (accumulate ops only).
- lo_i  in  WIDTH  current LO value (accumulate ops only).
- busy_o  out  1  high from the cycle after start is accepted until done_o is high, inclusive.
- done_o  out  1  one-cycle strobe: hi_o/lo_o valid, write HI/LO.
- hi_o  out  WIDTH  HI result (product[63:32] or remainder).
- lo_o  out  WIDTH  LO result (product[31:0] or quotient).

Behaviour:
- Reset (rst=0, async): state=IDLE, counter=0, busy_o=0, done_o=0, hi_o=0, lo_o=0, internal registers 0.
- FSM states: IDLE, PREP, CALC, FIX, DONE.
- IDLE: on start_i=1 with a valid op, latch op_i, opdata1_i, opdata2_i, hi_i, lo_i, then go to PREP.
- PREP (1 cycle):
  - Form absolute values for signed ops; record sign_q = a[31]^b[31] and sign_r = a[31].
  - Set divzero = (b==0) for div ops; clear the counter.
- CALC (WIDTH cycles, counter 0..WIDTH-1):
  - Multiply: if mplr LSB is set, add mcand into acc[63:32] (33-bit add), then shift acc right by 1.
  - Divide: shift {rem,quo} left by 1; trial = rem - divisor; if non-negative, rem=trial and quo LSB=1.
  - Leave CALC when counter==WIDTH-1.
- FIX (1 cycle):
  - Negate the product if signed and sign_q is set.
  - Negate the quotient if signed and sign_q; negate the remainder if signed and sign_r.
  - On divzero: lo = all ones, hi = original opdata1 (fixed, deterministic value; no trap).
- DONE (1 cycle): done_o=1 with hi_o/lo_o registered; then return to IDLE.
- Latency: start accepted at edge E0, done_o high in the cycle after edge E0+WIDTH+2, i.e. WIDTH+3 cycles (35 for WIDTH=32). Latency is identical for every op, including divzero.
- hi_o/lo_o hold their last value until the next DONE; done_o is high only in DONE.
- start_i while busy (not IDLE) is ignored; no queuing.
- flush_i=1 in any non-IDLE state: next state is IDLE, no done_o, busy_o drops next cycle. flush_i wins over start_i in the same cycle in IDLE (request dropped).
- Signed corner case: INT_MIN / -1 gives lo=0x80000000, hi=0, with no overflow flag.
- Arithmetic widths:
  - Signed MULT produces the full 64-bit two's-complement product.
  - MULTU is unsigned with no sign fix.
  - All negations are two's complement at WIDTH (divide) or 2*WIDTH (product).

Optional Feature:
- Macro MDU_MACC_EN.
- Defined: ops 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU. The product is computed as for MULT/MULTU. In FIX, {hi_q,lo_q} (latched at start) ± product becomes the result, modulo 2^64. Latency is unchanged.
- Undefined: op 1xx with start_i is ignored (stays IDLE, no busy_o, no done_o); hi_i/lo_i are unused.

Decomposition:
- Shared package/include (define.v): op encodings, FSM state encodings, the zero-word constant, and the active-low reset-level constant.
- One sub-module, mdu_div_step: combinational single restoring step (rem, quo, divisor in → rem, quo out), instantiated once inside CALC.

Test Plan:
- DIVU 100/7: start at cycle 0 → busy_o 1..35, done_o at cycle 35, lo=14, hi=2.
- DIV -7/2: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- INT_MIN/-1: lo=0x80000000, hi=0.
- MULT 0xFFFFFFFF×2: hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- MULTU with the same operands: hi=0x00000001, lo=0xFFFFFFFE.
- DIVU 5/0: done_o at cycle 35, lo=0xFFFFFFFF, hi=5. DIV 0x80000000/0: hi=0x80000000.
- Flush and restart:
  - Start MULT 3×4, flush_i at cycle 10: no done_o, busy_o=0 at cycle 11.
  - Extra start_i pulses at cycles 5–8 are ignored.
  - New start at cycle 12: done_o at cycle 47, lo=12, hi=0.
- Async reset at cycle 20 mid-DIV: outputs 0 immediately, without a clock edge. Release, then DIVU 9/3 → lo=3, hi=0.
- MDU_MACC_EN defined: hi_i=0, lo_i=10, MADD 3×4 → lo=22. MSUB 3×4 → lo=0xFFFFFFFE, hi=0xFFFFFFFF.
- MDU_MACC_EN undefined: op 100 ignored, with busy_o staying 0.
